// File: rtl/gun_hit_sequencer_if.sv
// Gun/timing-side signal bundle for gun_hit_sequencer: raw gun inputs and
// frame timing in, overlay command, shot result pulses and counters out.
`timescale 1ns/1ps
interface gun_hit_sequencer_if;
    logic       gun_trigger;
    logic       gun_photodetector;
    logic       frame_start;
    logic [1:0] overlay_mode;
    logic       busy;
    logic       hit;
    logic       miss;
    logic [7:0] shot_count;
    logic [7:0] hit_count;

    modport master (
        output gun_trigger, gun_photodetector, frame_start,
        input  overlay_mode, busy, hit, miss, shot_count, hit_count
    );

    modport slave (
        input  gun_trigger, gun_photodetector, frame_start,
        output overlay_mode, busy, hit, miss, shot_count, hit_count
    );
endinterface

// File: rtl/gun_hit_sequencer.sv
// Light-gun hit detection: debounced trigger, black frame, target frame, hit/miss.
// Optional GUN_CHEAT_CHECK_EN: light seen during the black frame forces a miss.
`timescale 1ns/1ps
module gun_hit_sequencer #(
    parameter int DEBOUNCE_CYCLES = 65000,
    parameter int DET_MIN_CYCLES  = 16,
    parameter int COOLDOWN_FRAMES = 8
) (
    input logic                clk,
    input logic                rst_n,
    gun_hit_sequencer_if.slave gun
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RUNW = $clog2(DET_MIN_CYCLES + 1);
    localparam int CDW  = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_BLACK, S_TARGET, S_RESULT, S_COOLDOWN
    } state_t;

    state_t          state;
    logic            trig_p0, trig_p1;
    logic            det_p0, det_p1;
    logic [DBW-1:0]  deb_cnt;
    logic [RUNW-1:0] run_cnt;
    logic [CDW-1:0]  cd_cnt;
    logic            seen_flag;
`ifdef GUN_CHEAT_CHECK_EN
    logic            cheat_flag;
`endif
    logic            press;
    logic            light_now;
    logic            result_hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0/p1: two-flop synchronizers for the asynchronous gun inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_p0 <= 1'b0;
            trig_p1 <= 1'b0;
            det_p0  <= 1'b0;
            det_p1  <= 1'b0;
        end else begin
            trig_p0 <= gun.gun_trigger;
            trig_p1 <= trig_p0;
            det_p0  <= gun.gun_photodetector;
            det_p1  <= det_p0;
        end
    end

    // Counter parks at DEBOUNCE_CYCLES so a held trigger fires exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
        end else if (!trig_p1) begin
            deb_cnt <= '0;
        end else if (deb_cnt != DBW'(DEBOUNCE_CYCLES)) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign press     = trig_p1 && (deb_cnt == DBW'(DEBOUNCE_CYCLES - 1));
    assign light_now = det_p1 && (run_cnt >= RUNW'(DET_MIN_CYCLES - 1));

    // The final cycle of TARGET still counts toward the decision
`ifdef GUN_CHEAT_CHECK_EN
    assign result_hit = (seen_flag || light_now) && !cheat_flag;
`else
    assign result_hit = seen_flag || light_now;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            gun.overlay_mode <= 2'd0;
            gun.busy         <= 1'b0;
            gun.hit          <= 1'b0;
            gun.miss         <= 1'b0;
            gun.shot_count   <= 8'd0;
            gun.hit_count    <= 8'd0;
            run_cnt          <= '0;
            cd_cnt           <= '0;
            seen_flag        <= 1'b0;
`ifdef GUN_CHEAT_CHECK_EN
            cheat_flag       <= 1'b0;
`endif
        end else begin
            gun.hit  <= 1'b0;
            gun.miss <= 1'b0;
            if (!det_p1) begin
                run_cnt <= '0;
            end else if (run_cnt != RUNW'(DET_MIN_CYCLES)) begin
                run_cnt <= run_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (press) begin
                        state          <= S_ARM;
                        gun.busy       <= 1'b1;
                        gun.shot_count <= sat_inc(gun.shot_count);
                        run_cnt        <= '0;
                        seen_flag      <= 1'b0;
`ifdef GUN_CHEAT_CHECK_EN
                        cheat_flag     <= 1'b0;
`endif
                    end
                end
                S_ARM: begin
                    if (gun.frame_start) begin
                        state            <= S_BLACK;
                        gun.overlay_mode <= 2'd1;
                        run_cnt          <= '0;
                    end
                end
                S_BLACK: begin
`ifdef GUN_CHEAT_CHECK_EN
                    if (light_now) cheat_flag <= 1'b1;
`endif
                    if (gun.frame_start) begin
                        state            <= S_TARGET;
                        gun.overlay_mode <= 2'd2;
                        run_cnt          <= '0;
                    end
                end
                S_TARGET: begin
                    if (light_now) seen_flag <= 1'b1;
                    if (gun.frame_start) begin
                        state            <= S_RESULT;
                        gun.overlay_mode <= 2'd0;
                        run_cnt          <= '0;
                        if (result_hit) begin
                            gun.hit       <= 1'b1;
                            gun.hit_count <= sat_inc(gun.hit_count);
                        end else begin
                            gun.miss <= 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    state   <= S_COOLDOWN;
                    cd_cnt  <= '0;
                    run_cnt <= '0;
                end
                S_COOLDOWN: begin
                    if (gun.frame_start) begin
                        if (cd_cnt == CDW'(COOLDOWN_FRAMES - 1)) begin
                            state    <= S_IDLE;
                            gun.busy <= 1'b0;
                            run_cnt  <= '0;
                        end else begin
                            cd_cnt <= cd_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state            <= S_IDLE;
                    gun.overlay_mode <= 2'd0;
                    gun.busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gun_hit_sequencer.sv
// Scoreboard bench for gun_hit_sequencer: randomized shots, expected hit/miss
// queued by a shot-level model and popped by an independent output monitor.
`timescale 1ns/1ps
module tb_gun_hit_sequencer;

`ifdef GUN_CHEAT_CHECK_EN
    localparam bit CHEAT_EN = 1'b1;
`else
    localparam bit CHEAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gun_hit_sequencer_if vif();

    gun_hit_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .DET_MIN_CYCLES (3),
        .COOLDOWN_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .gun  (vif)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int fper   = 100;
    int shots  = 0;
    int hits   = 0;
    bit expq[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        vif.frame_start = (cyc % fper == 0);
    endtask

    task automatic wait_frame();
        do tick(); while (!vif.frame_start);
    endtask

    // kind: 0 dark, 1 long run (light), 2 short run, 3 broken 1,1,0,1,1
    task automatic drive_det(input int kind, output bit lit);
        bit [4:0] pat;
        int n;
        pat = 5'b11011;
        lit = 1'b0;
        case (kind)
            1: begin
                n = $urandom_range(3, 8);
                lit = 1'b1;
                vif.gun_photodetector = 1'b1;
                repeat (n) tick();
            end
            2: begin
                n = $urandom_range(1, 2);
                vif.gun_photodetector = 1'b1;
                repeat (n) tick();
            end
            3: begin
                for (int i = 4; i >= 0; i--) begin
                    vif.gun_photodetector = pat[i];
                    tick();
                end
            end
            default: ;
        endcase
        vif.gun_photodetector = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_shot(input int kb, input int kt, input bit extra_press,
                           input bit abort, input bit hold_long);
        bit lit_b, lit_t, exp_hit;
        int t0;
        wait_frame();
        repeat (3) tick();
        vif.gun_trigger = 1'b1;
        t0 = cyc;
        repeat (hold_long ? 8 : $urandom_range(4, 8)) tick();
        if (!hold_long) vif.gun_trigger = 1'b0;
        repeat (2) tick();
        shots++;
        check("busy_armed", vif.busy, 1);
        check("shot_count", vif.shot_count, sat(shots));
        check("overlay_arm", vif.overlay_mode, 0);

        wait_frame();
        repeat (3) tick();
        check("overlay_black", vif.overlay_mode, 1);
        drive_det(kb, lit_b);

        wait_frame();
        repeat (3) tick();
        check("overlay_target", vif.overlay_mode, 2);
        drive_det(kt, lit_t);
        if (extra_press) begin
            vif.gun_trigger = 1'b1;
            repeat (6) tick();
            vif.gun_trigger = 1'b0;
            repeat (2) tick();
            check("shot_count_busy_press", vif.shot_count, sat(shots));
        end

        if (abort) begin
            rst_n = 1'b0;
            #1;
            check("rst_overlay", vif.overlay_mode, 0);
            check("rst_busy", vif.busy, 0);
            check("rst_hit_miss", {vif.hit, vif.miss}, 0);
            check("rst_shot_count", vif.shot_count, 0);
            check("rst_hit_count", vif.hit_count, 0);
            shots = 0;
            hits = 0;
            repeat (3) tick();
            rst_n = 1'b1;
            repeat (3) wait_frame();
            repeat (3) tick();
            check("post_abort_busy", vif.busy, 0);
            return;
        end

        exp_hit = lit_t && !(CHEAT_EN && lit_b);
        expq.push_back(exp_hit);
        if (exp_hit) hits++;

        wait_frame();
        repeat (3) tick();
        check("hit_count", vif.hit_count, sat(hits));
        check("busy_cooldown0", vif.busy, 1);
        check("overlay_cooldown", vif.overlay_mode, 0);
        wait_frame();
        repeat (3) tick();
        check("busy_cooldown1", vif.busy, 1);
        wait_frame();
        repeat (3) tick();
        check("busy_done", vif.busy, 0);

        if (hold_long) begin
            while (cyc - t0 < 1000) tick();
            check("held_busy", vif.busy, 0);
            check("held_shot_count", vif.shot_count, sat(shots));
            vif.gun_trigger = 1'b0;
            repeat (8) tick();
        end
    endtask

    // Monitor: every result pulse is matched against the oldest queued outcome
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            if (rst_n && (vif.hit || vif.miss)) begin
                check("hit_miss_exclusive", vif.hit & vif.miss, 0);
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pulse: hit=%0d miss=%0d with no shot pending (cycle %0d)",
                             vif.hit, vif.miss, cyc);
                end else begin
                    e = expq.pop_front();
                    check("result_hit", vif.hit, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vif.gun_trigger       = 1'b0;
        vif.gun_photodetector = 1'b0;
        vif.frame_start       = 1'b0;
        repeat (3) tick();
        check("reset_overlay", vif.overlay_mode, 0);
        check("reset_busy", vif.busy, 0);
        check("reset_hit_miss", {vif.hit, vif.miss}, 0);
        check("reset_shot_count", vif.shot_count, 0);
        check("reset_hit_count", vif.hit_count, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Too-short trigger must not register
        vif.gun_trigger = 1'b1;
        repeat (3) tick();
        vif.gun_trigger = 1'b0;
        repeat (10) tick();
        check("short_trig_busy", vif.busy, 0);
        check("short_trig_shots", vif.shot_count, 0);

        do_shot(0, 0, 1'b0, 1'b0, 1'b1);
        do_shot(0, 1, 1'b0, 1'b0, 1'b0);
        do_shot(1, 1, 1'b0, 1'b0, 1'b0);
        do_shot(0, 3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            do_shot($urandom_range(0, 3), $urandom_range(0, 3), 1'(($urandom_range(0, 1))), 1'b0, 1'b0);
        do_shot(0, 1, 1'b0, 1'b1, 1'b0);

        // Shorter frames to reach counter saturation quickly
        fper = 30;
        for (int i = 0; i < 257; i++)
            do_shot(0, 1, 1'b0, 1'b0, 1'b0);
        check("sat_shot_count", vif.shot_count, 255);
        check("sat_hit_count", vif.hit_count, 255);

        repeat (10) tick();
        check("pending_results", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
